// File: rtl/prog_seq_detector.sv
// Reloadable serial-pattern detector: programmable length, overlap mode, valid qualifier.
// Optional saturating match counter built when PROG_SEQ_DET_COUNT_EN is defined.
module prog_seq_detector #(
    parameter int W     = 5,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load,
    input  logic [W-1:0]           pat_in,
    input  logic [$clog2(W+1)-1:0] len_in,
    input  logic                   overlap,
    input  logic                   din_valid,
    input  logic                   din,
    output logic                   seen,
    output logic                   armed,
    output logic [CNT_W-1:0]       match_cnt
);

    localparam int LW = $clog2(W+1);
    localparam logic [LW-1:0] W_L = LW'(W);

    logic [W-1:0]  pat;
    logic [W-1:0]  hist;
    logic [LW-1:0] len;
    logic [LW-1:0] fill;

    logic [LW-1:0] len_c;
    logic [W-1:0]  load_mask;
    logic [W-1:0]  len_mask;
    logic [W-1:0]  hist_n;
    logic [LW-1:0] fill_inc;
    logic          hit;

    always_comb begin
        len_c     = (len_in > W_L) ? W_L : len_in;
        load_mask = '0;
        len_mask  = '0;
        for (int i = 0; i < W; i++) begin
            load_mask[i] = (LW'(i) < len_c);
            len_mask[i]  = (LW'(i) < len);
        end
        hist_n   = {hist[W-2:0], din};
        fill_inc = (fill == W_L) ? W_L : fill + 1'b1;
        // pat is stored pre-masked, so only the history needs masking
        hit      = armed && (fill_inc >= len) &&
                   ((hist_n & len_mask) == pat);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pat   <= '0;
            len   <= '0;
            hist  <= '0;
            fill  <= '0;
            seen  <= 1'b0;
            armed <= 1'b0;
        end else if (load) begin
            pat   <= pat_in & load_mask;
            len   <= len_c;
            armed <= (len_c != '0);
            hist  <= '0;
            fill  <= '0;
            seen  <= 1'b0;
        end else if (din_valid) begin
            hist <= hist_n;
            fill <= (hit && !overlap) ? '0 : fill_inc;
            seen <= hit;
        end else begin
            seen <= 1'b0;
        end
    end

`ifdef PROG_SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn || load) begin
            cnt_q <= '0;
        end else if (din_valid && hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_prog_seq_detector.sv
// Scoreboard bench for prog_seq_detector (W=5, CNT_W=2).
// A bit-queue reference model predicts seen/armed/match_cnt per cycle.
module tb_prog_seq_detector;

    localparam int W     = 5;
    localparam int CNT_W = 2;
    localparam int LW    = $clog2(W+1);

    logic             clk;
    logic             resetn;
    logic             load;
    logic [W-1:0]     pat_in;
    logic [LW-1:0]    len_in;
    logic             overlap;
    logic             din_valid;
    logic             din;
    logic             seen;
    logic             armed;
    logic [CNT_W-1:0] match_cnt;

    prog_seq_detector #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .pat_in    (pat_in),
        .len_in    (len_in),
        .overlap   (overlap),
        .din_valid (din_valid),
        .din       (din),
        .seen      (seen),
        .armed     (armed),
        .match_cnt (match_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic             seen;
        logic             armed;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_seen = 0;

    logic [W-1:0] m_pat;
    int           m_len = 0;
    logic         m_bits[$];
    int           m_cnt = 0;

    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (seen !== mon_e.seen) begin
                errors++;
                $display("FAIL seen t=%0t got %b exp %b", $time, seen, mon_e.seen);
            end
            checks++;
            if (armed !== mon_e.armed) begin
                errors++;
                $display("FAIL armed t=%0t got %b exp %b", $time, armed, mon_e.armed);
            end
            checks++;
            if (match_cnt !== mon_e.cnt) begin
                errors++;
                $display("FAIL match_cnt t=%0t got %0d exp %0d", $time, match_cnt, mon_e.cnt);
            end
            if (seen === 1'b1) n_seen++;
        end
    end

    function automatic logic [CNT_W-1:0] cnt_exp();
`ifdef PROG_SEQ_DET_COUNT_EN
        return CNT_W'(m_cnt);
`else
        return '0;
`endif
    endfunction

    task automatic step(input logic rn, input logic ld,
                        input logic [W-1:0] p, input logic [LW-1:0] l,
                        input logic ov, input logic v, input logic d);
        exp_t e;
        logic hit;
        resetn = rn; load = ld; pat_in = p; len_in = l;
        overlap = ov; din_valid = v; din = d;
        hit = 1'b0;
        if (!rn) begin
            m_pat = '0; m_len = 0; m_cnt = 0; m_bits.delete();
        end else if (ld) begin
            m_len = (int'(l) > W) ? W : int'(l);
            m_pat = p;
            for (int i = 0; i < W; i++) if (i >= m_len) m_pat[i] = 1'b0;
            m_cnt = 0;
            m_bits.delete();
        end else if (v) begin
            m_bits.push_back(d);
            if (m_bits.size() > W) void'(m_bits.pop_front());
            if (m_len > 0 && m_bits.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (m_bits[m_bits.size()-1-i] != m_pat[i]) hit = 1'b0;
            end
            if (hit) begin
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (!ov) m_bits.delete();
            end
        end
        e.seen  = hit;
        e.armed = (m_len != 0);
        e.cnt   = cnt_exp();
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic bit1(input logic d, input logic ov);
        step(1'b1, 1'b0, '0, '0, ov, 1'b1, d);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_load(input logic [W-1:0] p, input logic [LW-1:0] l);
        step(1'b1, 1'b1, p, l, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic send(input logic [15:0] b, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--) bit1(b[i], ov);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 5'b11111, 3'd5, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        idle();
        checks++;
        if (armed !== 1'b0 || seen !== 1'b0 || match_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state got a=%b s=%b c=%0d exp 0", armed, seen, match_cnt);
        end
    endtask

    task automatic test_basic();
        int n0;
        do_load(5'b10110, 3'd5);
        n0 = n_seen;
        send(16'b10110, 5, 1'b1);
        idle();
        checks++;
        if (n_seen - n0 != 1) begin
            errors++;
            $display("FAIL basic_pulses got %0d exp 1", n_seen - n0);
        end
        checks++;
        if (match_cnt !== cnt_exp() || armed !== 1'b1) begin
            errors++;
            $display("FAIL basic_cnt got %0d/%b exp %0d/1", match_cnt, armed, cnt_exp());
        end
    endtask

    task automatic test_overlap();
        int n0;
        do_load(5'b00101, 3'd3);
        n0 = n_seen;
        send(16'b10101, 5, 1'b1);
        idle();
        checks++;
        if (n_seen - n0 != 2) begin
            errors++;
            $display("FAIL overlap1_pulses got %0d exp 2", n_seen - n0);
        end
        do_load(5'b00101, 3'd3);
        n0 = n_seen;
        send(16'b10101, 5, 1'b0);
        idle();
        checks++;
        if (n_seen - n0 != 1) begin
            errors++;
            $display("FAIL overlap0_pulses got %0d exp 1", n_seen - n0);
        end
    endtask

    task automatic test_gaps();
        int n0;
        do_load(5'b10110, 3'd5);
        n0 = n_seen;
        send(16'b10, 2, 1'b1);
        repeat (3) idle();
        send(16'b110, 3, 1'b1);
        idle();
        checks++;
        if (n_seen - n0 != 1) begin
            errors++;
            $display("FAIL gaps_pulses got %0d exp 1", n_seen - n0);
        end
    endtask

    task automatic test_reload();
        int n0;
        do_load(5'b10110, 3'd5);
        send(16'b1011, 4, 1'b1);
        n0 = n_seen;
        do_load(5'b10110, 3'd5);
        bit1(1'b0, 1'b1);
        idle();
        checks++;
        if (n_seen != n0) begin
            errors++;
            $display("FAIL reload_nohit got %0d exp 0", n_seen - n0);
        end
        send(16'b10110, 5, 1'b1);
        idle();
        checks++;
        if (n_seen - n0 != 1) begin
            errors++;
            $display("FAIL reload_hit got %0d exp 1", n_seen - n0);
        end
    endtask

    task automatic test_len_edges();
        int n0;
        do_load(5'b11111, 3'd0);
        n0 = n_seen;
        repeat (8) bit1(1'b0, 1'b1);
        repeat (8) bit1(1'b1, 1'b1);
        idle();
        checks++;
        if (n_seen != n0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL len0 got %0d/%b exp 0/0", n_seen - n0, armed);
        end
        do_load(5'b01101, 3'd7);
        n0 = n_seen;
        send(16'b1101, 4, 1'b1);
        send(16'b01101, 5, 1'b1);
        idle();
        checks++;
        if (n_seen - n0 != 1) begin
            errors++;
            $display("FAIL len_clamp got %0d exp 1", n_seen - n0);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        do_load(5'b11111, 3'd1);
        n0 = n_seen;
        repeat (5) bit1(1'b1, 1'b1);
        idle();
        checks++;
        if (n_seen - n0 != 5) begin
            errors++;
            $display("FAIL b2b_pulses got %0d exp 5", n_seen - n0);
        end
        checks++;
        if (match_cnt !== cnt_exp()) begin
            errors++;
            $display("FAIL b2b_sat got %0d exp %0d", match_cnt, cnt_exp());
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        do_load(5'b10110, 3'd5);
        send(16'b101, 3, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        n0 = n_seen;
        send(16'b1010110, 7, 1'b1);
        idle();
        checks++;
        if (n_seen != n0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got %0d/%b exp 0/0", n_seen - n0, armed);
        end
    endtask

    initial begin
        resetn = 1'b0; load = 1'b0; pat_in = '0; len_in = '0;
        overlap = 1'b1; din_valid = 1'b0; din = 1'b0;
        m_pat = '0;
        test_reset();
        test_basic();
        test_overlap();
        test_gaps();
        test_reload();
        test_len_edges();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
